wide_add_seq: RTL and testbench

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq.sv | 161 ++++++++++++++++
 tb/tb_wide_add_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// wide_add_seq
//
// Sequential wide adder/subtractor. A single N-bit ripple-carry adder is
// reused once per word, least significant word first, so a W = N*K bit
// operation takes K cycles of RUN before the result is offered downstream.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request operands valid
//   in_ready   block accepts a request this cycle (IDLE only)
//   in_a       operand A (W bits)
//   in_b       operand B (W bits)
//   in_sub     0 = A+B, 1 = A-B
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts the result
//   out_sum    result modulo 2^W
//   out_cout   carry out of bit W-1 (for subtract, 1 = no borrow)
//   out_ovf    two's-complement signed overflow
//   busy       high while an operation is in RUN or DONE

module wide_add_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   in_a,
  input  logic [N*K-1:0]   in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int W  = N * K;
  localparam int IW = (K == 1) ? 1 : $clog2(K) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry;
  logic [IW-1:0]  idx;

  logic [N-1:0]   a_word;
  logic [N-1:0]   b_word;
  logic [N-1:0]   add_sum;
  logic [N:0]     chain;
  logic           add_cout;

  // Select the operand word currently being processed. The loop builds a
  // plain K-way mux keyed by the word index; B is already the effective
  // operand (inverted at accept time for subtraction).
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int k = 0; k < K; k++) begin
      if (idx == IW'(k)) begin
        a_word = a_reg[k*N +: N];
        b_word = b_reg[k*N +: N];
      end
    end
  end

  // The shared N-bit ripple-carry adder: a chain of full adders whose carry
  // in is the carry register, so the carry ripples between words through
  // that register from one cycle to the next.
  always_comb begin
    chain    = '0;
    add_sum  = '0;
    chain[0] = carry;
    for (int i = 0; i < N; i++) begin
      add_sum[i]   = a_word[i] ^ b_word[i] ^ chain[i];
      chain[i+1]   = (a_word[i] & b_word[i]) | (chain[i] & (a_word[i] ^ b_word[i]));
    end
  end

  assign add_cout = chain[N];

  // The carry register is left holding the carry out of the final word when
  // RUN finishes, so it doubles as the carry-out result in DONE.
  assign out_cout = carry;
  assign busy     = (state != IDLE);

  // Control FSM and datapath registers. Subtraction is A + ~B + 1: B is
  // inverted on the way in and the initial carry is in_sub. Each RUN cycle
  // writes one result word in place. Overflow is captured on the last word,
  // where the adder is looking at the top bits of A and effective B.
  // in_ready is registered from the next state so it is low throughout reset
  // and rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_sub ? ~in_b : in_b;
            carry    <= in_sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end

        RUN: begin
          for (int k = 0; k < K; k++) begin
            if (idx == IW'(k)) begin
              out_sum[k*N +: N] <= add_sum;
            end
          end
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_ovf   <= (a_word[N-1] == b_word[N-1]) & (add_sum[N-1] != a_word[N-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq
//
// Directed testbench for wide_add_seq with N=4, K=4 (16-bit operands).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_wide_add_seq;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  b2b_a   [4];
  logic [W-1:0]  b2b_b   [4];
  logic [W+1:0]  b2b_exp [4];

  wide_add_seq #(
    .N(N),
    .K(K)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation with out_ready low, checks latency and result, then
  // optionally holds the result for hold_cycles while offering a stray
  // request, and finally releases it. Must be called at a falling edge.
  task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic sub,
                               input logic [W-1:0] exp_sum, input logic exp_cout,
                               input logic exp_ovf, input int hold_cycles);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " ready"}, in_ready, 1);
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sub   = 1'b0;
    checkOutput({tag, " run"}, {out_valid, in_ready, busy}, 3'b001);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, K);
    checkOutput({tag, " sum"}, out_sum, exp_sum);
    checkOutput({tag, " cout"}, out_cout, exp_cout);
    checkOutput({tag, " ovf"}, out_ovf, exp_ovf);
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid = 1'b1;
      in_a     = 16'hFFFF;
      in_b     = 16'h0001;
      @(negedge clk);
      checkOutput({tag, " hold"}, {out_valid, in_ready, busy, out_cout, out_ovf, out_sum},
                  {3'b101, exp_cout, exp_ovf, exp_sum});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " release"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  // Main directed sequence.
  initial begin
    int i;
    int j;
    int cyc;
    int last;

    b2b_a[0] = 16'h0001; b2b_b[0] = 16'h0002; b2b_exp[0] = {1'b0, 1'b0, 16'h0003};
    b2b_a[1] = 16'h1111; b2b_b[1] = 16'h2222; b2b_exp[1] = {1'b0, 1'b0, 16'h3333};
    b2b_a[2] = 16'hF000; b2b_b[2] = 16'h1000; b2b_exp[2] = {1'b1, 1'b0, 16'h0000};
    b2b_a[3] = 16'h4000; b2b_b[3] = 16'h4000; b2b_exp[3] = {1'b0, 1'b1, 16'h8000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset ctrl", {out_valid, in_ready, busy, out_cout, out_ovf}, 5'b00000);
    checkOutput("reset sum", out_sum, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", {in_ready, busy, out_valid}, 3'b100);

    $display("[TB] directed arithmetic");
    applyStimulus("add",      16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
    applyStimulus("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    applyStimulus("add ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    applyStimulus("sub neg",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    applyStimulus("sub ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    applyStimulus("sub zero", 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus("backpr",   16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 10);

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    in_sub    = 1'b0;
    i    = 0;
    j    = 0;
    cyc  = 0;
    last = 0;
    while (j < 4 && cyc < 80) begin
      if (in_ready) begin
        if (i < 4) begin
          in_a     = b2b_a[i];
          in_b     = b2b_b[i];
          in_valid = 1'b1;
          i++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        checkOutput("b2b result", {out_cout, out_ovf, out_sum}, b2b_exp[j]);
        if (j > 0) begin
          checkOutput("b2b period", cyc - last, K + 2);
        end
        last = cyc;
        j++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b count", j, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset during run");
    checkOutput("pre-abort ready", in_ready, 1);
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort ctrl", {out_valid, in_ready, busy, out_cout, out_ovf}, 5'b00000);
    checkOutput("abort sum", out_sum, 16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("abort held", {out_valid, in_ready, busy, out_cout, out_ovf, out_sum}, 21'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort recover", {in_ready, busy, out_valid}, 3'b100);
    applyStimulus("post abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
